// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one-outstanding-request memory interface feeding a
// two-entry instruction buffer, with branch redirect and in-flight data discard.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | one cycle after reset, no request issued
// FETCH   | normal operation, requests issued while buffer has room
// DISCARD | redirect hit an in-flight request; wait for its ack and drop data
module instruction_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        CLK,
   input  logic        RST,
   output logic [31:0] MemAddress,
   output logic        MemReadEnable,
   input  logic        MemAck,
   input  logic [31:0] MemInstr,
   output logic        InstrValid,
   input  logic        InstrReady,
   output logic [31:0] FetchedInstr,
   output logic [31:0] FetchedPC,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   localparam logic [1:0] FULL_COUNT = FIFO_DEPTH[1:0];

   state_t      state, state_nxt;
   logic [31:0] pc;
   logic [31:0] req_addr;
   logic        outstanding;
   logic [1:0]  count, count_nxt;
   logic [31:0] e0_instr, e0_pc, e1_instr, e1_pc;

   logic        ack_ok;
   logic        push, pop;
   logic        wr_head;
   logic        unused_redirect_lsb;

   assign unused_redirect_lsb = ^RedirectPC[1:0];

   // Acks only count against a request we actually have in flight.
   assign ack_ok = MemAck & outstanding;

   always_comb begin
      state_nxt     = state;
      MemReadEnable = 1'b0;
      case (state)
         S_IDLE: begin
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            MemReadEnable = outstanding | (count != FULL_COUNT);
            if (Redirect && MemReadEnable && !ack_ok)
               state_nxt = S_DISCARD;
         end
         S_DISCARD: begin
            MemReadEnable = 1'b1;
            if (ack_ok)
               state_nxt = S_FETCH;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign push       = (state == S_FETCH) & ack_ok & ~Redirect;
   assign pop        = InstrValid & InstrReady & ~Redirect;
   assign MemAddress = (state == S_DISCARD) ? req_addr : pc;

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 2'd1;
         2'b01:   count_nxt = count - 2'd1;
         default: count_nxt = count;
      endcase
      if (Redirect)
         count_nxt = 2'd0;
   end

   // Push lands at the head slot when the buffer is, or is about to become, empty.
   assign wr_head = (count == 2'd0) | ((count == 2'd1) & pop);

   assign InstrValid   = (count != 2'd0);
   assign FetchedInstr = InstrValid ? e0_instr : 32'h0;
   assign FetchedPC    = InstrValid ? e0_pc    : 32'h0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         outstanding <= 1'b0;
         count       <= 2'd0;
         e0_instr    <= 32'h0;
         e0_pc       <= 32'h0;
         e1_instr    <= 32'h0;
         e1_pc       <= 32'h0;
      end else begin
         state       <= state_nxt;
         outstanding <= MemReadEnable & ~ack_ok;
         count       <= count_nxt;
         if (state != S_DISCARD)
            req_addr <= pc;

         if (Redirect)
            pc <= {RedirectPC[31:2], 2'b00};
         else if (push)
            pc <= pc + 32'd4;

         if (pop) begin
            e0_instr <= e1_instr;
            e0_pc    <= e1_pc;
         end
         if (push) begin
            if (wr_head) begin
               e0_instr <= MemInstr;
               e0_pc    <= pc;
            end else begin
               e1_instr <= MemInstr;
               e1_pc    <= pc;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST)
         assert (!(push && (count == FULL_COUNT)));
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 2, the fetched-instruction buffer depth; only value 2 is supported.
REQ-003 CLK  input  1  the single clock; all state updates on posedge CLK.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 MemAddress  output  32  byte address to instruction memory.
REQ-006 MemReadEnable  output  1  read request to instruction memory.
REQ-007 MemAck  input  1  memory acknowledge, registered, high the cycle after a request cycle.
REQ-008 MemInstr  input  32  memory read data, valid only while MemReadEnable=1.
REQ-009 InstrValid  output  1  buffer head holds a valid instruction for decode.
REQ-010 InstrReady  input  1  decode accepts the head entry when InstrValid=1.
REQ-011 FetchedInstr  output  32  head instruction word.
REQ-012 FetchedPC  output  32  byte address of the head instruction.
REQ-013 Redirect  input  1  branch/jump redirect strobe.
REQ-014 RedirectPC  input  32  new fetch address; bits [1:0] are ignored and treated as 0.

Function
REQ-015 The FSM SHALL have three states: IDLE, FETCH and DISCARD.
REQ-016 IDLE SHALL last exactly one cycle after reset and then go to FETCH.
REQ-017 The PC register SHALL hold the next fetch address, and MemAddress SHALL equal PC in every state except DISCARD.
REQ-018 In FETCH, a request SHALL start (MemReadEnable=1) only when buffer occupancy is below 2 or a request is already outstanding.
REQ-019 An outstanding request SHALL hold MemReadEnable=1 and a stable MemAddress until the cycle MemAck=1, inclusive.
REQ-020 In a MemAck=1 cycle in FETCH, MemInstr and PC SHALL be pushed into the buffer, PC SHALL advance by 4 (mod 2^32, wrapping from FFFF_FFFC to 0), and a new request MAY begin the next cycle; peak throughput is one instruction per 2 cycles.
REQ-021 The buffer SHALL be a 2-entry FIFO; InstrValid SHALL equal (occupancy != 0), FetchedInstr/FetchedPC SHALL show the head entry, and InstrValid&InstrReady SHALL pop it.
REQ-022 A simultaneous push and pop SHALL keep occupancy unchanged and preserve order.
REQ-023 A push into a full buffer SHALL be impossible by construction under REQ-018; an assertion SHALL flag it.
REQ-024 On Redirect=1, the buffer SHALL flush (InstrValid=0 next cycle) and PC SHALL load {RedirectPC[31:2],2'b00}.
REQ-025 Redirect with an outstanding request and MemAck=0 SHALL go to DISCARD, holding MemReadEnable=1 and the old MemAddress until MemAck=1, then drop that data and return to FETCH.
REQ-026 Redirect coinciding with MemAck=1 SHALL drop the acked data and stay in FETCH; redirect wins over push.
REQ-027 Redirect while in DISCARD SHALL overwrite PC only, and the FSM SHALL remain in DISCARD.
REQ-028 Redirect coinciding with a pop SHALL flush; the pop has no additional effect.
REQ-029 Redirect in IDLE SHALL load PC, and IDLE SHALL still proceed to FETCH.

Reset
REQ-030 On RST=1 the block SHALL set: state=IDLE, PC=RESET_PC, occupancy=0, outstanding=0, MemReadEnable=0, InstrValid=0.
REQ-031 FetchedInstr and FetchedPC SHALL be 0 while the buffer is empty after reset.
REQ-032 RST SHALL take priority over Redirect and MemAck in the same cycle.
REQ-033 Reset during an outstanding request SHALL abandon it, and a stray MemAck while in IDLE SHALL be ignored.

Verification
REQ-034 Cold start: RST released at cycle 0, InstrReady=1 -> cycle 1 MemReadEnable=1 with MemAddress=0; cycle 2 MemAck=1; cycle 3 InstrValid=1 with FetchedPC=0, FetchedInstr=RAM[0].
REQ-035 Backpressure: InstrReady=0 for 10 cycles -> exactly 2 requests issued, buffer holds PCs 0 and 4, and MemReadEnable=0 afterwards; InstrReady=1 -> PCs 0, 4, 8 are delivered in order.
REQ-036 Redirect during an outstanding request: Redirect with RedirectPC=32'h40 and MemAck=0 -> DISCARD, the next MemAck data is not delivered, and the first delivered instruction has FetchedPC=32'h40.
REQ-037 Redirect coinciding with MemAck=1 and RedirectPC=32'h23 -> acked data dropped, and the next delivery has FetchedPC=32'h20.
REQ-038 Wrap: RedirectPC=32'hFFFF_FFFC -> delivered FetchedPC sequence FFFF_FFFC, 0000_0000.
REQ-039 Reset mid-operation: RST asserted with 2 entries buffered and a request outstanding -> next cycle InstrValid=0, MemReadEnable=0, and the next fetch is from RESET_PC.
